// File: rtl/cordic_arbiter.sv
// Two-requester round-robin front end for a shared, non-stalling cosine pipeline.
// Credits reserve a result FIFO slot at accept time, so a tag leaving the pipe always finds room.
module cordic_arbiter #(
  parameter int unsigned LATENCY    = 5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic [31:0] pipe_in,
  input  logic [31:0] pipe_out,
  output logic        res0_valid,
  output logic [31:0] res0_data,
  input  logic        res0_ready,
  output logic        res1_valid,
  output logic [31:0] res1_data,
  input  logic        res1_ready,
  output logic        busy
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam logic [CW:0] DEPTH_LIM = FIFO_DEPTH[CW:0];

  logic [1:0]         req_valid;
  logic [1:0]         res_ready;
  logic [31:0]        req_data [2];

  logic [CW-1:0]      count_q    [2];
  logic [CW-1:0]      count_d    [2];
  logic [CW-1:0]      inflight_q [2];
  logic [CW-1:0]      inflight_d [2];
  logic [AW-1:0]      wptr_q     [2];
  logic [AW-1:0]      wptr_d     [2];
  logic [AW-1:0]      rptr_q     [2];
  logic [AW-1:0]      rptr_d     [2];
  logic [31:0]        mem_q      [2][FIFO_DEPTH];

  logic [LATENCY-1:0] tag_valid_q;
  logic [LATENCY-1:0] tag_valid_d;
  logic [LATENCY-1:0] tag_id_q;
  logic [LATENCY-1:0] tag_id_d;

  logic               ptr_q;
  logic               ptr_d;

  logic [1:0]         eligible;
  logic [1:0]         accept;
  logic [1:0]         push;
  logic [1:0]         pop;
  logic [1:0]         nonempty;
  logic               any_accept;
  logic               grant_id;

  assign req_valid   = {req1_valid, req0_valid};
  assign res_ready   = {res1_ready, res0_ready};
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;

  // A requester may issue only while its buffered plus in-flight results leave a free slot.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      eligible[i] = req_valid[i] &&
                    (({1'b0, count_q[i]} + {1'b0, inflight_q[i]}) < DEPTH_LIM);
      nonempty[i] = (count_q[i] != '0);
    end
  end

  always_comb begin
    any_accept = 1'b0;
    grant_id   = 1'b0;
    if (!rst) begin
      case (eligible)
        2'b01: begin
          any_accept = 1'b1;
          grant_id   = 1'b0;
        end
        2'b10: begin
          any_accept = 1'b1;
          grant_id   = 1'b1;
        end
        2'b11: begin
          any_accept = 1'b1;
          grant_id   = ptr_q;
        end
        default: begin
          any_accept = 1'b0;
          grant_id   = 1'b0;
        end
      endcase
    end
    accept    = 2'b00;
    accept[0] = any_accept & ~grant_id;
    accept[1] = any_accept & grant_id;
    ptr_d     = any_accept ? ~grant_id : ptr_q;
  end

  assign req0_ready = accept[0];
  assign req1_ready = accept[1];
  assign pipe_in    = any_accept ? req_data[grant_id] : 32'h0000_0000;

  // Tags track which requester owns the value currently emerging from the pipeline.
  always_comb begin
    tag_valid_d    = '0;
    tag_id_d       = '0;
    tag_valid_d[0] = any_accept;
    tag_id_d[0]    = grant_id;
    for (int s = 1; s < LATENCY; s++) begin
      tag_valid_d[s] = tag_valid_q[s-1];
      tag_id_d[s]    = tag_id_q[s-1];
    end
  end

  assign push[0] = tag_valid_q[LATENCY-1] & ~tag_id_q[LATENCY-1];
  assign push[1] = tag_valid_q[LATENCY-1] & tag_id_q[LATENCY-1];
  assign pop     = res_ready & nonempty;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      count_d[i]    = count_q[i];
      inflight_d[i] = inflight_q[i];
      wptr_d[i]     = wptr_q[i] + AW'(push[i]);
      rptr_d[i]     = rptr_q[i] + AW'(pop[i]);
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
      case ({accept[i], push[i]})
        2'b10:   inflight_d[i] = inflight_q[i] + CW'(1);
        2'b01:   inflight_d[i] = inflight_q[i] - CW'(1);
        default: inflight_d[i] = inflight_q[i];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_q <= '0;
      tag_id_q    <= '0;
      ptr_q       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        count_q[i]    <= '0;
        inflight_q[i] <= '0;
        wptr_q[i]     <= '0;
        rptr_q[i]     <= '0;
      end
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
      ptr_q       <= ptr_d;
      for (int i = 0; i < 2; i++) begin
        count_q[i]    <= count_d[i];
        inflight_q[i] <= inflight_d[i];
        wptr_q[i]     <= wptr_d[i];
        rptr_q[i]     <= rptr_d[i];
      end
    end
  end

  // Storage has no reset; occupancy is governed entirely by the counters above.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst && push[i]) begin
        mem_q[i][wptr_q[i]] <= pipe_out;
      end
    end
  end

  assign res0_valid = !rst && nonempty[0];
  assign res1_valid = !rst && nonempty[1];
  assign res0_data  = mem_q[0][rptr_q[0]];
  assign res1_data  = mem_q[1][rptr_q[1]];

  assign busy = !rst && ((inflight_q[0] != '0) || (inflight_q[1] != '0) ||
                         nonempty[0] || nonempty[1]);

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations and a long random traffic run.
module tb_cordic_arbiter;

  localparam int unsigned LATENCY = 5;
  localparam int unsigned DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [31:0] pipe_in, pipe_out;
  logic        res0_valid, res1_valid;
  logic [31:0] res0_data, res1_data;
  logic        res0_ready, res1_ready;
  logic        busy;

  always #5 clk = ~clk;

  cordic_arbiter #(
    .LATENCY   (LATENCY),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .pipe_in   (pipe_in),
    .pipe_out  (pipe_out),
    .res0_valid(res0_valid),
    .res0_data (res0_data),
    .res0_ready(res0_ready),
    .res1_valid(res1_valid),
    .res1_data (res1_data),
    .res1_ready(res1_ready),
    .busy      (busy)
  );

  // Stand-in for the cosine pipeline: fixed latency, cos(0) maps to 1.0f.
  function automatic logic [31:0] fake_cos(input logic [31:0] x);
    return x + 32'h3F80_0000;
  endfunction

  logic [31:0] psh [LATENCY];
  always @(posedge clk) begin
    psh[0] <= pipe_in;
    for (int s = 1; s < LATENCY; s++) psh[s] <= psh[s-1];
  end
  assign pipe_out = fake_cos(psh[LATENCY-1]);

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: per-requester queue of outstanding ops, each with the cycle its
  // result becomes visible (accept cycle + LATENCY + 1).
  typedef struct {
    int unsigned rc;
    logic [31:0] v;
  } op_t;

  op_t  q0[$];
  op_t  q1[$];
  logic mptr = 1'b0;

  always @(negedge clk) begin
    int          g;
    logic        e0, e1, v0, v1;
    logic [31:0] ep;
    op_t         op;
    if (rst) begin
      check("rst_outputs", 32'({req0_ready, req1_ready, res0_valid, res1_valid, busy}), 32'd0);
      check("rst_pipe_in", pipe_in, 32'd0);
      q0.delete();
      q1.delete();
      mptr = 1'b0;
    end else begin
      e0 = req0_valid && (q0.size() < DEPTH);
      e1 = req1_valid && (q1.size() < DEPTH);
      g  = -1;
      if (e0 && e1) g = mptr ? 1 : 0;
      else if (e0) g = 0;
      else if (e1) g = 1;
      ep = (g == 0) ? req0_data : (g == 1) ? req1_data : 32'd0;
      v0 = (q0.size() > 0) && (q0[0].rc <= cyc);
      v1 = (q1.size() > 0) && (q1[0].rc <= cyc);
      check("ready0", 32'(req0_ready), 32'(g == 0));
      check("ready1", 32'(req1_ready), 32'(g == 1));
      check("pipe_in", pipe_in, ep);
      check("res0_valid", 32'(res0_valid), 32'(v0));
      check("res1_valid", 32'(res1_valid), 32'(v1));
      if (v0) check("res0_data", res0_data, fake_cos(q0[0].v));
      if (v1) check("res1_data", res1_data, fake_cos(q1[0].v));
      check("busy", 32'(busy), 32'((q0.size() > 0) || (q1.size() > 0)));
      if (v0 && res0_ready) void'(q0.pop_front());
      if (v1 && res1_ready) void'(q1.pop_front());
      if (g == 0) begin
        op.rc = cyc + LATENCY + 1;
        op.v  = req0_data;
        q0.push_back(op);
        mptr = 1'b1;
      end else if (g == 1) begin
        op.rc = cyc + LATENCY + 1;
        op.v  = req1_data;
        q1.push_back(op);
        mptr = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 32'd0;
    req1_data  = 32'd0;
    res0_ready = 1'b1;
    res1_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] dvec [4];
  int          t0, lat, acc1, g;
  logic        found;

  initial begin
    rst = 1'b1;
    idle_inputs();
    dvec[0] = 32'h0000_1111;
    dvec[1] = 32'h0000_2222;
    dvec[2] = 32'h0000_3333;
    dvec[3] = 32'h0000_4444;

    // Single op: accept in cycle 0, result visible in cycle 6.
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 32'h0000_0000;
    @(negedge clk);
    t0 = int'(cyc);
    check("single_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      check("single_busy", 32'(busy), 32'd1);
      if (res0_valid) begin
        found = 1'b1;
        lat   = int'(cyc) - t0;
        check("single_data", res0_data, 32'h3F80_0000);
      end
      tick();
    end
    check("single_latency", 32'(lat), 32'd6);
    @(negedge clk);
    check("single_idle", 32'(busy), 32'd0);
    tick();

    // Contention: grants alternate starting with requester 0.
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 32'h0000_0100;
    req1_data  = 32'h0000_0200;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g = req1_ready ? 1 : (req0_ready ? 0 : 2);
      check("contention_grant", 32'(g), 32'(i % 2));
      tick();
      req0_data = req0_data + 1;
      req1_data = req1_data + 1;
    end
    idle_inputs();
    repeat (10) tick();

    // Backpressure on requester 1: credits allow exactly DEPTH accepts.
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    res1_ready = 1'b0;
    acc1 = 0;
    for (int i = 0; i < 20; i++) begin
      req0_data = 32'h0001_0000 + i;
      req1_data = 32'h0002_0000 + i;
      @(negedge clk);
      if (req1_ready) acc1++;
      tick();
    end
    check("bp_accepts", 32'(acc1), 32'd4);
    res1_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_valid", 32'(res1_valid), 32'd1);
    tick();
    res1_ready = 1'b0;
    acc1 = 0;
    for (int i = 0; i < 15; i++) begin
      req1_data = 32'h0003_0000 + i;
      @(negedge clk);
      if (req1_ready) acc1++;
      tick();
    end
    check("bp_after_pop", 32'(acc1), 32'd1);
    idle_inputs();
    repeat (12) tick();

    // Three results buffered, fourth exits the pipe in the same cycle as a pop.
    do_reset();
    res0_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req0_valid = 1'b1;
      req0_data  = dvec[k];
      @(negedge clk);
      tick();
    end
    req0_valid = 1'b0;
    repeat (8) tick();
    req0_valid = 1'b1;
    req0_data  = dvec[3];
    @(negedge clk);
    check("full_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    repeat (4) tick();
    res0_ready = 1'b1;
    @(negedge clk);
    check("full_head_before", res0_data, fake_cos(dvec[0]));
    tick();
    res0_ready = 1'b0;
    @(negedge clk);
    check("full_valid_after", 32'(res0_valid), 32'd1);
    check("full_head_after", res0_data, fake_cos(dvec[1]));
    tick();
    res0_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      check("full_drain", res0_data, fake_cos(dvec[j]));
      tick();
    end
    @(negedge clk);
    check("full_empty", 32'({res0_valid, busy}), 32'd0);
    tick();

    // Reset three cycles after two accepts discards everything.
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 32'h0000_0AAA;
    @(negedge clk);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    req1_data  = 32'h0000_0BBB;
    @(negedge clk);
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd0);
    tick();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rst_mid_no_result", 32'({res0_valid, res1_valid}), 32'd0);
      tick();
    end

    // Random traffic, fully checked by the reference model.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_data  = $urandom;
      req1_data  = $urandom;
      res0_ready = ($urandom_range(0, 2) != 0);
      res1_ready = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      tick();
    end
    idle_inputs();
    repeat (LATENCY + 2 * DEPTH + 4) tick();
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
